car_lanes: RTL and testbench

//  Downstream follower of the vertical scroller. Holds 4 lanes, one car each. Each

---
 rtl/car_lanes.sv | 164 ++++++++++++++++
 tb/tb_car_lanes.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/car_lanes.sv
// car_lanes
//   Downstream follower of the vertical scroller. Holds four lanes with one car
//   in each. Each move_followers pulse moves every lane down MOVE_AMT pixels,
//   wrapping at the bottom of the screen. A lane that wraps picks up a new
//   speed and direction from a free-running LFSR. On each frame_tick, every car
//   moves horizontally and wraps at the screen edges.
//
// Ports
//   clk             in   pixel clock
//   reset           in   synchronous, active-high
//   frame_tick      in   one-cycle pulse per frame; moves cars horizontally
//   move_followers  in   one-cycle pulse from the scroller; moves lanes down
//   pix_x, pix_y    in   current beam position
//   player_x/_y     in   player box top-left corner
//   car_on          out  beam is on a car; registered, 1-cycle latency
//   collision       out  sticky; player box overlapped a car on a frame_tick
//   lane_reseed     out  one-cycle pulse the cycle after any lane reseeded
module car_lanes #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned MOVE_AMT   = 2,
    parameter int unsigned LANE_PITCH = 120,
    parameter int unsigned CAR_W      = 48,
    parameter int unsigned CAR_H      = 32,
    parameter int unsigned PLAYER_W   = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_followers,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       car_on,
    output logic       collision,
    output logic       lane_reseed
);

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned CAR_X_PITCH = SCREEN_W / NUM_LANES;

    localparam logic [10:0] W11     = 11'(SCREEN_W);
    localparam logic [10:0] H11     = 11'(SCREEN_H);
    localparam logic [10:0] MOVE11  = 11'(MOVE_AMT);
    localparam logic [10:0] CAR_W11 = 11'(CAR_W);
    localparam logic [10:0] CAR_H11 = 11'(CAR_H);
    localparam logic [10:0] PLY11   = 11'(PLAYER_W);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Distance from b forward to a on a ring of size m.
    function automatic logic [10:0] md(input logic [10:0] a,
                                       input logic [10:0] b,
                                       input logic [10:0] m);
        md = (a >= b) ? (a - b) : (a - b + m);
    endfunction

    // Registered state
    logic [9:0]  lane_y [NUM_LANES];
    logic [9:0]  car_x  [NUM_LANES];
    logic [1:0]  speed  [NUM_LANES];
    logic        dir    [NUM_LANES];   // 1 = moving left
    logic [15:0] lfsr;

    // Next-state and per-lane intermediates
    logic [9:0]  lane_y_nxt [NUM_LANES];
    logic [9:0]  car_x_nxt  [NUM_LANES];
    logic [1:0]  speed_nxt  [NUM_LANES];
    logic        dir_nxt    [NUM_LANES];
    logic [10:0] y_sum      [NUM_LANES];
    logic [10:0] x_move     [NUM_LANES];
    logic [10:0] spd11      [NUM_LANES];
    logic [1:0]  seed_bits  [NUM_LANES];
    logic [NUM_LANES-1:0] reseed;
    logic [NUM_LANES-1:0] pix_hit;
    logic [NUM_LANES-1:0] ply_hit;
    logic [15:0] lfsr_nxt;
    logic        pix_visible;

    always_comb begin
        lfsr_nxt    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
        pix_visible = ({1'b0, pix_x} < W11) && ({1'b0, pix_y} < H11);

        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_y_nxt[i] = lane_y[i];
            car_x_nxt[i]  = car_x[i];
            speed_nxt[i]  = speed[i];
            dir_nxt[i]    = dir[i];
            reseed[i]     = 1'b0;
            spd11[i]      = {9'b0, speed[i]};
            x_move[i]     = {1'b0, car_x[i]};
            seed_bits[i]  = lfsr[3*i +: 2];

            // Vertical scroll with wrap; a wrapping lane reseeds from the
            // current LFSR value.
            y_sum[i] = {1'b0, lane_y[i]} + MOVE11;
            if (move_followers) begin
                if (y_sum[i] >= H11) begin
                    lane_y_nxt[i] = 10'(y_sum[i] - H11);
                    reseed[i]     = 1'b1;
                end else begin
                    lane_y_nxt[i] = y_sum[i][9:0];
                end
            end

            // A reseed only changes speed/dir; the horizontal move below
            // still uses the registered (old) values in the same cycle.
            if (reseed[i]) begin
                speed_nxt[i] = (seed_bits[i] == 2'd0) ? 2'd1 : seed_bits[i];
                dir_nxt[i]   = lfsr[3*i + 2];
            end

            if (frame_tick) begin
                if (!dir[i]) begin
                    x_move[i] = {1'b0, car_x[i]} + spd11[i];
                    if (x_move[i] >= W11)
                        x_move[i] = x_move[i] - W11;
                end else if ({1'b0, car_x[i]} < spd11[i]) begin
                    x_move[i] = {1'b0, car_x[i]} + W11 - spd11[i];
                end else begin
                    x_move[i] = {1'b0, car_x[i]} - spd11[i];
                end
                car_x_nxt[i] = x_move[i][9:0];
            end

            pix_hit[i] = (md({1'b0, pix_x}, {1'b0, car_x[i]}, W11) < CAR_W11) &&
                         (md({1'b0, pix_y}, {1'b0, lane_y[i]}, H11) < CAR_H11);

            ply_hit[i] = ((md({1'b0, player_x}, {1'b0, car_x[i]}, W11) < CAR_W11) ||
                          (md({1'b0, car_x[i]}, {1'b0, player_x}, W11) < PLY11)) &&
                         ((md({1'b0, player_y}, {1'b0, lane_y[i]}, H11) < CAR_H11) ||
                          (md({1'b0, lane_y[i]}, {1'b0, player_y}, H11) < PLY11));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                lane_y[i] <= 10'(i * LANE_PITCH);
                car_x[i]  <= 10'(i * CAR_X_PITCH);
                speed[i]  <= 2'd1;
                dir[i]    <= i[0];
            end
            lfsr        <= LFSR_SEED;
            car_on      <= 1'b0;
            collision   <= 1'b0;
            lane_reseed <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                lane_y[i] <= lane_y_nxt[i];
                car_x[i]  <= car_x_nxt[i];
                speed[i]  <= speed_nxt[i];
                dir[i]    <= dir_nxt[i];
            end
            lfsr        <= lfsr_nxt;
            car_on      <= pix_visible && (|pix_hit);
            lane_reseed <= |reseed;
            if (frame_tick && (|ply_hit))
                collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_car_lanes.sv
// tb_car_lanes
//   Directed bench for car_lanes. Car and lane positions are observed through
//   car_on by probing pixels just inside and just outside each car edge.
//   A bench-side LFSR model predicts the speed/direction chosen on reseed.
module tb_car_lanes;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       move_followers;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       car_on;
    logic       collision;
    logic       lane_reseed;

    int n_cmp = 0;
    int n_bad = 0;
    int reseed_cnt = 0;

    logic [15:0] m_lfsr;
    logic [15:0] snap_lfsr;

    car_lanes #(
        .SCREEN_W  (640),
        .SCREEN_H  (480),
        .MOVE_AMT  (2),
        .LANE_PITCH(120),
        .CAR_W     (48),
        .CAR_H     (32),
        .PLAYER_W  (32),
        .LFSR_SEED (SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .move_followers(move_followers),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .player_x      (player_x),
        .player_y      (player_y),
        .car_on        (car_on),
        .collision     (collision),
        .lane_reseed   (lane_reseed)
    );

    always #20 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR; snap_lfsr holds the value seen on the latest
    // move_followers cycle, which is the one a reseed would use.
    always @(posedge clk) begin
        if (move_followers)
            snap_lfsr <= m_lfsr;
        if (reset)
            m_lfsr <= SEED;
        else
            m_lfsr <= lfsr_step(m_lfsr);
    end

    always @(negedge clk)
        if (lane_reseed === 1'b1)
            reseed_cnt++;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic ft, input logic mf);
        @(negedge clk);
        frame_tick     = ft;
        move_followers = mf;
        @(posedge clk);
        #1;
        frame_tick     = 1'b0;
        move_followers = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input int exp);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge clk);
        #1;
        check(tag, int'(car_on), exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int sp;
    int x3;
    int base;

    initial begin
        reset          = 1'b1;
        frame_tick     = 1'b0;
        move_followers = 1'b0;
        pix_x          = '0;
        pix_y          = '0;
        player_x       = 10'd0;
        player_y       = 10'd420;   // no lane y-overlap while lanes sit at 0/120/240/360

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_car_on", int'(car_on), 0);
        check("rst_collision", int'(collision), 0);
        check("rst_lane_reseed", int'(lane_reseed), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: basic pixel hits from reset layout
        probe("t1_in", 10, 10, 1);
        probe("t1_right_edge", 48, 10, 0);
        probe("t1_offscreen", 700, 10, 0);
        probe("t1_last_col", 47, 31, 1);
        probe("t1_below", 47, 32, 0);

        // 2: three frame ticks
        repeat (3) cycle(1'b1, 1'b0);
        probe("t2_car0_in", 3, 0, 1);
        probe("t2_car0_out", 2, 0, 0);
        probe("t2_car1_in", 157, 130, 1);
        probe("t2_car1_out", 156, 130, 0);
        probe("t2_car2_in", 323, 250, 1);
        probe("t2_car2_out", 322, 250, 0);
        probe("t2_car3_in", 477, 370, 1);
        probe("t2_car3_out", 476, 370, 0);

        // 3: car0 driven to x=638, straddles the right edge
        do_reset();
        repeat (638) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        probe("t3_wrap_in", 20, 5, 1);
        probe("t3_wrap_out", 46, 5, 0);
        probe("t3_start_in", 638, 5, 1);
        probe("t3_start_out", 637, 5, 0);
        check("t3_no_collision", int'(collision), 0);

        // 4: 60 move pulses, lane 3 wraps to y=0 and reseeds
        do_reset();
        base = reseed_cnt;
        repeat (59) cycle(1'b0, 1'b1);
        check("t4_no_early_reseed", int'(lane_reseed), 0);
        cycle(1'b0, 1'b1);
        check("t4_reseed_pulse", int'(lane_reseed), 1);
        probe("t4_lane3_top", 480, 0, 1);
        check("t4_reseed_drop", int'(lane_reseed), 0);
        probe("t4_lane3_bot_in", 490, 31, 1);
        probe("t4_lane3_bot_out", 490, 32, 0);
        probe("t4_lane3_above", 480, 479, 0);
        probe("t4_lane0_in", 10, 120, 1);
        probe("t4_lane0_out", 10, 119, 0);
        check("t4_reseed_count", reseed_cnt - base, 1);
        sp = (snap_lfsr[10:9] == 2'd0) ? 1 : int'(snap_lfsr[10:9]);
        x3 = snap_lfsr[11] ? 480 - sp : 480 + sp;
        cycle(1'b1, 1'b0);
        probe("t4_car3_new_in", x3, 0, 1);
        probe("t4_car3_new_out", x3 - 1, 0, 0);

        // 5: sticky collision
        do_reset();
        check("t5_pre", int'(collision), 0);
        @(negedge clk);
        player_x = 10'd10;
        player_y = 10'd10;
        cycle(1'b1, 1'b0);
        check("t5_hit", int'(collision), 1);
        @(negedge clk);
        player_x = 10'd300;
        player_y = 10'd60;
        cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        check("t5_sticky", int'(collision), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_reset_clears", int'(collision), 0);
        @(negedge clk);
        reset    = 1'b0;
        player_x = 10'd0;
        player_y = 10'd420;

        // 6: tick and move together; reseeded lane keeps old speed this tick
        repeat (59) cycle(1'b0, 1'b1);
        check("t6_no_early_reseed", int'(lane_reseed), 0);
        cycle(1'b1, 1'b1);
        check("t6_reseed_pulse", int'(lane_reseed), 1);
        probe("t6_car0_in", 1, 120, 1);
        check("t6_reseed_drop", int'(lane_reseed), 0);
        probe("t6_car0_x_out", 0, 120, 0);
        probe("t6_car0_y_out", 1, 119, 0);
        probe("t6_car3_old_in", 479, 0, 1);
        probe("t6_car3_old_out", 478, 0, 0);
        sp = (snap_lfsr[10:9] == 2'd0) ? 1 : int'(snap_lfsr[10:9]);
        x3 = snap_lfsr[11] ? 479 - sp : 479 + sp;
        cycle(1'b1, 1'b0);
        probe("t6_car3_new_in", x3, 0, 1);
        probe("t6_car3_new_out", x3 - 1, 0, 0);
        check("t6_no_collision", int'(collision), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
